// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for a single-ALU RV32I datapath (addi, add).
// Define MULTICYCLE_CTRL_BNE_EN to also decode bne; otherwise bne is illegal and eq is ignored.
module multicycle_ctrl #(
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   ADDRESS_WIDTH  = 5,
  parameter int                   ALU_INST_WIDTH = 1,
  parameter int                   PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [PC_WIDTH-1:0]       pc,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instr,
  output logic [ADDRESS_WIDTH-1:0]  rs1,
  output logic [ADDRESS_WIDTH-1:0]  rs2,
  output logic [ADDRESS_WIDTH-1:0]  rd,
  output logic [DATA_WIDTH-1:0]     ImmOp,
  output logic                      ALUsrc,
  output logic [ALU_INST_WIDTH-1:0] ALUctrl,
  output logic                      RegWrite,
  input  logic                      eq,
  output logic                      busy,
  output logic                      illegal
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ADDI, OP_ADD, OP_BNE} op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [31:0]               ir_q, ir_d;
  logic [ADDRESS_WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic                      alusrc_q, alusrc_d;
  logic                      taken_q, taken_d;

  op_e                       dec_op;
  logic [DATA_WIDTH-1:0]     imm_i, imm_b;
  logic [PC_WIDTH-1:0]       pc_plus4;

  assign imm_i    = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_b    = {{(DATA_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  // Instruction classification from the latched word; anything unmatched is illegal.
  always_comb begin
    dec_op = OP_NONE;
    if (ir_q[6:0] == OPC_OP_IMM && ir_q[14:12] == 3'b000)
      dec_op = OP_ADDI;
    else if (ir_q[6:0] == OPC_OP && ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'b0000000)
      dec_op = OP_ADD;
`ifdef MULTICYCLE_CTRL_BNE_EN
    else if (ir_q[6:0] == OPC_BRANCH && ir_q[14:12] == 3'b001)
      dec_op = OP_BNE;
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    alusrc_d = alusrc_q;
    taken_d  = taken_q;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rs1_d    = ADDRESS_WIDTH'(ir_q[19:15]);
        rs2_d    = ADDRESS_WIDTH'(ir_q[24:20]);
        rd_d     = ADDRESS_WIDTH'(ir_q[11:7]);
        op_d     = dec_op;
        imm_d    = '0;
        alusrc_d = 1'b0;
        taken_d  = 1'b0;
        unique case (dec_op)
          OP_ADDI: begin
            imm_d    = imm_i;
            alusrc_d = 1'b1;
          end
          OP_BNE:  imm_d = imm_b;
          default: ;
        endcase
        if (dec_op == OP_NONE) begin
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
`ifdef MULTICYCLE_CTRL_BNE_EN
        taken_d = (op_q == OP_BNE) && !eq;
`endif
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
`ifdef MULTICYCLE_CTRL_BNE_EN
        // The offset is sign-extended (or truncated) to the PC width before the add.
        pc_d = taken_q ? pc_q + PC_WIDTH'($signed(imm_q)) : pc_plus4;
`else
        pc_d = pc_plus4;
`endif
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      op_q     <= OP_NONE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      alusrc_q <= alusrc_d;
      taken_q  <= taken_d;
    end
  end

`ifndef MULTICYCLE_CTRL_BNE_EN
  logic unused_eq;
  assign unused_eq = eq;
`endif

  assign pc          = pc_q;
  assign instr_ready = (state_q == S_FETCH);
  assign busy        = (state_q != S_FETCH);
  assign illegal     = (state_q == S_DECODE) && (dec_op == OP_NONE);
  assign RegWrite    = (state_q == S_WRITEBACK) && (op_q == OP_ADDI || op_q == OP_ADD) && (rd_q != '0);
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign ImmOp       = imm_q;
  assign ALUsrc      = alusrc_q;
  assign ALUctrl     = '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected results are queued at issue and compared
// as the controller walks each instruction through its states.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum int {K_ADDI, K_ADD, K_BNE, K_BAD} kind_e;

  typedef struct {
    logic [31:0] word;
    bit          eq;
    kind_e       kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          alusrc;
  } stim_t;

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          alusrc;
    bit          ill;
    bit          wr;
    logic [31:0] pc_after;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic        ALUsrc;
  logic [0:0]  ALUctrl;
  logic        RegWrite;
  logic        eq = 1'b0;
  logic        busy;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_pc = '0;
  exp_t exp_q[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .RegWrite(RegWrite), .eq(eq), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  // Push the expected outcome, then perform the FETCH handshake (called at a negedge).
  task automatic issue(input stim_t s, input bit track);
    exp_t e;
    int   waited;
    e.rd = s.rd; e.rs1 = s.rs1; e.rs2 = s.rs2; e.imm = s.imm; e.alusrc = s.alusrc;
    e.ill = (s.kind == K_BAD) || (s.kind == K_BNE && !BNE_EN);
    e.wr  = !e.ill && (s.kind == K_ADDI || s.kind == K_ADD) && (s.rd != 5'd0);
    e.pc_after = (!e.ill && s.kind == K_BNE && !s.eq) ? model_pc + s.imm : model_pc + 32'd4;
    if (track) begin
      exp_q.push_back(e);
      model_pc = e.pc_after;
    end
    instr = s.word;
    eq = s.eq;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) check("handshake_timeout", 32'(instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Watch the instruction to completion (starting at the negedge after the handshake) and compare.
  task automatic observe();
    exp_t e;
    int ill_cnt = 0, ill_at = 0, rw_cnt = 0, rw_at = 0, done_at = 0;
    logic [4:0]  s_rd = '0, s_rs1 = '0, s_rs2 = '0;
    logic [31:0] s_imm = '0;
    logic        s_alusrc = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (illegal)  begin ill_cnt++; ill_at = c; end
      if (RegWrite) begin rw_cnt++;  rw_at = c;  end
      if (c == 2 && busy) begin
        s_rd = rd; s_rs1 = rs1; s_rs2 = rs2; s_imm = ImmOp; s_alusrc = ALUsrc;
      end
      if (!busy) begin done_at = c; break; end
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("illegal_pulses", 32'(ill_cnt), e.ill ? 32'd1 : 32'd0);
    check("regwrite_pulses", 32'(rw_cnt), e.wr ? 32'd1 : 32'd0);
    check("done_cycle", 32'(done_at), e.ill ? 32'd2 : 32'd4);
    if (e.ill) check("illegal_cycle", 32'(ill_at), 32'd1);
    if (e.wr)  check("regwrite_cycle", 32'(rw_at), 32'd3);
    if (!e.ill) begin
      check("rd", 32'(s_rd), 32'(e.rd));
      check("rs1", 32'(s_rs1), 32'(e.rs1));
      check("rs2", 32'(s_rs2), 32'(e.rs2));
      check("imm", s_imm, e.imm);
      check("alusrc", 32'(s_alusrc), 32'(e.alusrc));
      check("aluctrl", 32'(ALUctrl), 32'd0);
    end
    check("pc_after", pc, e.pc_after);
    check("ready_after", 32'(instr_ready), 32'd1);
  endtask

  stim_t prog[$];

  initial begin
    prog.push_back('{32'h00500093, 1'b0, K_ADDI, 5'd1,  5'd0, 5'd5,  32'd5,        1'b1});
    prog.push_back('{32'hFFF00113, 1'b0, K_ADDI, 5'd2,  5'd0, 5'd31, 32'hFFFFFFFF, 1'b1});
    prog.push_back('{32'hFE209CE3, 1'b0, K_BNE,  5'd25, 5'd1, 5'd2,  32'hFFFFFFF8, 1'b0});
    prog.push_back('{32'h00500093, 1'b0, K_ADDI, 5'd1,  5'd0, 5'd5,  32'd5,        1'b1});
    prog.push_back('{32'h002081B3, 1'b0, K_ADD,  5'd3,  5'd1, 5'd2,  32'd0,        1'b0});
    prog.push_back('{32'hFE209CE3, 1'b1, K_BNE,  5'd25, 5'd1, 5'd2,  32'hFFFFFFF8, 1'b0});
    prog.push_back('{32'h00000000, 1'b0, K_BAD,  5'd0,  5'd0, 5'd0,  32'd0,        1'b0});
    prog.push_back('{32'h00208033, 1'b0, K_ADD,  5'd0,  5'd1, 5'd2,  32'd0,        1'b0});
    prog.push_back('{32'h00209863, 1'b0, K_BNE,  5'd16, 5'd1, 5'd2,  32'd16,       1'b0});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_decode", {rd, rs1, rs2, 16'(ALUsrc)}, 32'd0);
    check("rst_imm", ImmOp, 32'd0);

    for (int i = 0; i < prog.size(); i++) begin
      if (i == 1) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_pc", pc, model_pc);
          check("stall_busy", 32'(busy), 32'd0);
        end
      end
      issue(prog[i], 1'b1);
      observe();
    end

    // Reset in EXECUTE of an addi x5,x0,5: nothing must be written, next fetch from reset PC.
    issue('{32'h00500293, 1'b0, K_ADDI, 5'd5, 5'd0, 5'd5, 32'd5, 1'b1}, 1'b0);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_decode", {rd, rs1, rs2, 16'(ALUsrc)}, 32'd0);
    begin
      int rw_seen = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (RegWrite) rw_seen++;
      end
      check("mid_rst_no_write", 32'(rw_seen), 32'd0);
    end
    rst_n = 1'b1;
    model_pc = '0;
    @(negedge clk);
    issue(prog[0], 1'b1);
    observe();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the single-ALU/register-file datapath. It fetches one 32-bit RV32I word per instruction over a valid/ready handshake and decodes `addi`, `add` and, optionally, `bne`. It drives register addresses, immediate, operand select, ALU control and write enable to the datapath, and owns the program counter. Each instruction completes in four cycles when the instruction source has no stalls.

## Interface
- `DATA_WIDTH`, default 32: width of the datapath and `ImmOp`.
- `ADDRESS_WIDTH`, default 5: register address width.
- `ALU_INST_WIDTH`, default 1: width of `ALUctrl`. Encoding 0 = add; 1 is reserved and never driven.
- `PC_WIDTH`, default 32: program counter width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc` output PC_WIDTH: fetch address.
- `instr_valid` input 1: `instr` holds the word at `pc`.
- `instr_ready` output 1: controller accepts `instr` this cycle.
- `instr` input 32: instruction word.
- `rs1`, `rs2`, `rd` output ADDRESS_WIDTH: register addresses.
- `ImmOp` output DATA_WIDTH: sign-extended immediate.
- `ALUsrc` output 1: 1 selects `ImmOp` as the second ALU operand.
- `ALUctrl` output ALU_INST_WIDTH: ALU operation.
- `RegWrite` output 1: register file write enable.
- `eq` input 1: ALU equality flag from the datapath.
- `busy` output 1: high in every state except FETCH.
- `illegal` output 1: one-cycle pulse when an unsupported word is decoded.

## Operation
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH.
- Reset values:
  - state = FETCH, `pc` = RESET_PC.
  - `rs1`, `rs2`, `rd`, `ImmOp`, `ALUsrc`, `ALUctrl`, `RegWrite`, `illegal` all = 0.
  - `instr_ready` = 1, `busy` = 0.
- FETCH:
  - `instr_ready` = 1 and `pc` is held stable.
  - On `instr_valid && instr_ready`, `instr` is latched into an internal IR and the state moves to DECODE.
  - Otherwise the controller stays in FETCH indefinitely.
- DECODE:
  - IR fields are registered: `rs1`=IR[19:15], `rs2`=IR[24:20], `rd`=IR[11:7].
  - `ImmOp` and `ALUsrc` are registered for the decoded instruction. The registered outputs change at the end of this cycle and are held through WRITEBACK.
  - `addi` (opcode 0010011, funct3 000): ImmOp = sext(IR[31:20]), ALUsrc=1, ALUctrl=0.
  - `add` (opcode 0110011, funct3 000, funct7 0000000): ALUsrc=0, ALUctrl=0, ImmOp=0.
  - `bne` (opcode 1100011, funct3 001): ImmOp = sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}), ALUsrc=0.
  - Any other word is illegal: `illegal` pulses for one cycle and the controller returns to FETCH with `pc` += 4. `RegWrite` stays 0.
- EXECUTE: the ALU operands are stable. For `bne`, `eq` is sampled at the end of this cycle.
- WRITEBACK:
  - `addi`/`add`: `RegWrite`=1 for exactly this cycle, unless `rd`=0, in which case `RegWrite` stays 0.
  - `bne`: `RegWrite`=0. `pc` becomes `pc`+ImmOp (truncated to PC_WIDTH) if the sampled `eq`=0, else `pc`+4.
  - Non-branch instructions: `pc` += 4.
  - `pc` updates at the end of WRITEBACK. Arithmetic wraps modulo 2^PC_WIDTH.
- Asynchronous reset asserted in any state forces all reset values immediately. The in-flight instruction is discarded with no write.

## Timing
- Latency: 4 cycles per instruction from the FETCH handshake to the next FETCH, plus any cycles spent waiting for `instr_valid`.
- `RegWrite` is high in the third cycle after the handshake. The register file commits on that cycle's closing edge.
- `instr_ready` is combinational from state only. It never depends on `instr_valid`.
- Decode outputs (`rs1`, `rs2`, `rd`, `ImmOp`, `ALUsrc`, `ALUctrl`) are stable from the end of DECODE until the next DECODE. `eq` is therefore valid throughout EXECUTE.

## Configuration
- `MULTICYCLE_CTRL_BNE_EN`:
  - Defined: `bne` is decoded as above.
  - Undefined: opcode 1100011 is illegal. `illegal` pulses, `pc` += 4, no branch logic or `eq` sampling is synthesised, and the `eq` port remains present but unused.

## Test plan
- Reset: hold `rst_n`=0, release → `pc`=0, `instr_ready`=1, `busy`=0, `RegWrite`=0, all decode outputs 0.
- `addi x1,x0,5` (0x00500093) with `instr_valid` continuously high:
  - Decode outputs: `rd`=1, `rs1`=0, `ImmOp`=5, `ALUsrc`=1.
  - `RegWrite`=1 in exactly one cycle (handshake+3); `pc` then reads 4.
- Stall: `instr_valid`=0 for 5 cycles → `pc` and state stay in FETCH. Assert valid → normal 4-cycle sequence.
- `bne` at `pc`=8 with imm −8 (0xFE209CE3, `bne x1,x2,-8`):
  - Drive `eq`=0 → `pc`=0.
  - Repeat with `eq`=1 → `pc`=12.
  - Without `MULTICYCLE_CTRL_BNE_EN` → `illegal` pulse, `pc`=12.
- Illegal word 0x00000000 → one-cycle `illegal` in DECODE, no `RegWrite`, `pc`+=4. `add x0,x1,x2` → `RegWrite` never asserts.
- `rst_n` dropped during EXECUTE of an `addi` → immediate return to reset values, no `RegWrite` pulse, next fetch at RESET_PC.
